// File: rtl/proc_pkg.sv
// Shared fetch-stage types and constants: NOP encoding, FSM states, PC width
// and the pc_gen select codes.
package proc_pkg;

    localparam int          PC_W       = 32;
    localparam logic [31:0] NOP_INSN_C = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_KEEP     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_gen.sv
// Program counter register with its next-pc mux (reset / redirect / +4 / hold).
module pc_gen
    import proc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_t         i_sel,
    input  logic [PC_W-1:0] i_redirect_pc,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_plus4
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;

    // +4 wraps naturally at 2^32
    assign o_pc_plus4 = r_pc + 32'd4;
    assign o_pc       = r_pc;

    // next-pc select
    always_comb begin
        w_pc_nxt = r_pc;
        case (i_sel)
            PC_INC:      w_pc_nxt = o_pc_plus4;
            PC_REDIRECT: w_pc_nxt = word_align(i_redirect_pc);
            default:     w_pc_nxt = r_pc;
        endcase
    end

    // pc register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= word_align(RESET_PC);
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage feeding the IF/ID register.
// Optional FETCH_PERF_EN adds fetch_count / bubble_count performance counters.
module instruction_fetch
    import proc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = NOP_INSN_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        stall_mem,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] curr_pc,
    output logic [31:0] next_pc,
    output logic        if_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    pc_sel_t      w_pc_sel;
    logic [31:0]  r_hold;
    logic [31:0]  r_instr;
    logic [31:0]  r_curr_pc;
    logic [31:0]  r_next_pc;
    logic [31:0]  w_pc;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_insn_src;
    logic         w_accept;
    logic         w_load_insn;
    logic         w_load_nop;
    logic         w_hold_cap;
    logic         w_hold_clr;

    pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst           (rst),
        .i_sel         (w_pc_sel),
        .i_redirect_pc (redirect_pc),
        .o_pc          (w_pc),
        .o_pc_plus4    (w_pc_plus4)
    );

    assign w_accept = ~hazard & ~stall_mem;

    // fetch FSM next-state, IF/ID load and hold-buffer control; flush dominates
    always_comb begin
        w_state_nxt = r_state;
        w_pc_sel    = PC_KEEP;
        w_load_insn = 1'b0;
        w_load_nop  = 1'b0;
        w_insn_src  = r_hold;
        w_hold_cap  = 1'b0;
        w_hold_clr  = 1'b0;
        if (flush) begin
            w_pc_sel   = PC_REDIRECT;
            w_load_nop = 1'b1;
            w_hold_clr = 1'b1;
            // a request still in flight must be drained before refetching
            if (((r_state == WAIT) || (r_state == DRAIN)) && !imem_rdy) begin
                w_state_nxt = DRAIN;
            end else begin
                w_state_nxt = FETCH;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    w_state_nxt = WAIT;
                    w_load_nop  = w_accept;
                end
                WAIT: begin
                    if (imem_rdy) begin
                        if (w_accept) begin
                            w_load_insn = 1'b1;
                            w_insn_src  = imem_rdata;
                            w_pc_sel    = PC_INC;
                            w_state_nxt = FETCH;
                        end else begin
                            w_hold_cap  = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end else begin
                        w_load_nop = w_accept;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        w_load_insn = 1'b1;
                        w_insn_src  = r_hold;
                        w_pc_sel    = PC_INC;
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end
                DRAIN: begin
                    w_load_nop = w_accept;
                    if (imem_rdy) begin
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // hold buffer for a response that arrived while decode was not accepting
    always_ff @(posedge clk) begin
        if (rst || w_hold_clr) begin
            r_hold <= 32'h0000_0000;
        end else if (w_hold_cap) begin
            r_hold <= imem_rdata;
        end else begin
            r_hold <= r_hold;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst || w_load_nop) begin
            r_instr   <= NOP_INSN;
            r_curr_pc <= 32'h0000_0000;
            r_next_pc <= 32'h0000_0000;
        end else if (w_load_insn) begin
            r_instr   <= w_insn_src;
            r_curr_pc <= w_pc;
            r_next_pc <= w_pc_plus4;
        end else begin
            r_instr   <= r_instr;
            r_curr_pc <= r_curr_pc;
            r_next_pc <= r_next_pc;
        end
    end

    // reset and a same-cycle flush both suppress the request so it never goes stale
    assign imem_req    = (r_state == FETCH) & ~rst & ~flush;
    assign imem_addr   = w_pc;
    assign instruction = r_instr;
    assign curr_pc     = r_curr_pc;
    assign next_pc     = r_next_pc;
    assign if_busy     = (r_state != HOLD);

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    // real-instruction and bubble load counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= 32'h0000_0000;
            r_bubble_cnt <= 32'h0000_0000;
        end else if (w_load_insn) begin
            r_fetch_cnt  <= r_fetch_cnt + 32'd1;
        end else if (w_load_nop) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else begin
            r_fetch_cnt  <= r_fetch_cnt;
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    assign fetch_count  = r_fetch_cnt;
    assign bubble_count = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Table-driven bench for instruction_fetch: per-cycle stimulus with expected
// request/address (mid-cycle) and IF/ID/busy (after the edge) via a scoreboard.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rst, haz, stl, fl, rdy;
        logic [31:0] rpc, rdat;
        logic        pre;
        logic        e_req;
        logic [31:0] e_addr, e_ins, e_cur, e_nxt;
        logic        e_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0;
    logic        stall_mem = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction, curr_pc, next_pc;
    logic        if_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, bubble_count;
`endif

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSN (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .stall_mem    (stall_mem),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdy     (imem_rdy),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .curr_pc      (curr_pc),
        .next_pc      (next_pc),
        .if_busy      (if_busy)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    task automatic add(input logic r, h, s, f, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] rdat,
                       input logic pre, input logic req, input logic [31:0] addr,
                       input logic [31:0] ins, cur, nxt, input logic busy);
        vec_t v;
        v.rst = r; v.haz = h; v.stl = s; v.fl = f; v.rpc = rpc;
        v.rdy = rdy; v.rdat = rdat; v.pre = pre; v.e_req = req; v.e_addr = addr;
        v.e_ins = ins; v.e_cur = cur; v.e_nxt = nxt; v.e_busy = busy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        //   rst h s f  rpc           rdy rdata         pre req addr          ins           cur           nxt           busy
        // reset, then straight-line fetch with one-cycle memory latency
        add(1,0,0,0, 32'h0,         0, 32'h0,         0, 0, 32'h0,        NOP,          32'h0,        32'h0,        1); // 0
        add(1,0,0,0, 32'h0,         0, 32'h0,         1, 0, 32'h0,        NOP,          32'h0,        32'h0,        1); // 1
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h0,        NOP,          32'h0,        32'h0,        1); // 2
        add(0,0,0,0, 32'h0,         1, 32'h00100093,  1, 0, 32'h0,        32'h00100093, 32'h0,        32'h4,        1); // 3
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h4,        NOP,          32'h0,        32'h0,        1); // 4
        add(0,0,0,0, 32'h0,         1, 32'h00200113,  1, 0, 32'h4,        32'h00200113, 32'h4,        32'h8,        1); // 5
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h8,        NOP,          32'h0,        32'h0,        1); // 6
        add(0,0,0,0, 32'h0,         1, 32'h00300193,  1, 0, 32'h8,        32'h00300193, 32'h8,        32'hC,        1); // 7
        // reset, then response under a 3-cycle load-use hazard
        add(1,0,0,0, 32'h0,         0, 32'h0,         1, 0, 32'hC,        NOP,          32'h0,        32'h0,        1); // 8
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h0,        NOP,          32'h0,        32'h0,        1); // 9
        add(0,1,0,0, 32'h0,         1, 32'h00A00093,  1, 0, 32'h0,        NOP,          32'h0,        32'h0,        0); // 10
        add(0,1,0,0, 32'h0,         0, 32'h0,         1, 0, 32'h0,        NOP,          32'h0,        32'h0,        0); // 11
        add(0,1,0,0, 32'h0,         0, 32'h0,         1, 0, 32'h0,        NOP,          32'h0,        32'h0,        0); // 12
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 0, 32'h0,        32'h00A00093, 32'h0,        32'h4,        1); // 13
        // flush in WAIT, late response dropped through DRAIN
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h4,        NOP,          32'h0,        32'h0,        1); // 14
        add(0,0,0,1, 32'h100,       0, 32'h0,         1, 0, 32'h4,        NOP,          32'h0,        32'h0,        1); // 15
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 0, 32'h100,      NOP,          32'h0,        32'h0,        1); // 16
        add(0,0,0,0, 32'h0,         1, 32'hDEADBEEF,  1, 0, 32'h100,      NOP,          32'h0,        32'h0,        1); // 17
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h100,      NOP,          32'h0,        32'h0,        1); // 18
        // stall_mem holds the response, then a flush discards the hold buffer
        add(0,0,1,0, 32'h0,         1, 32'h00500293,  1, 0, 32'h100,      NOP,          32'h0,        32'h0,        0); // 19
        add(0,0,1,0, 32'h0,         0, 32'h0,         1, 0, 32'h100,      NOP,          32'h0,        32'h0,        0); // 20
        add(0,0,1,1, 32'h200,       0, 32'h0,         1, 0, 32'h100,      NOP,          32'h0,        32'h0,        1); // 21
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h200,      NOP,          32'h0,        32'h0,        1); // 22
        add(0,0,0,0, 32'h0,         1, 32'h00600313,  1, 0, 32'h200,      32'h00600313, 32'h200,      32'h204,      1); // 23
        // redirect to the top word (low bits ignored), pc+4 wraps to 0
        add(0,0,0,1, 32'hFFFFFFFF,  0, 32'h0,         1, 0, 32'h204,      NOP,          32'h0,        32'h0,        1); // 24
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'hFFFFFFFC, NOP,          32'h0,        32'h0,        1); // 25
        add(0,0,0,0, 32'h0,         1, 32'h00700393,  1, 0, 32'hFFFFFFFC, 32'h00700393, 32'hFFFFFFFC, 32'h0,        1); // 26
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h0,        NOP,          32'h0,        32'h0,        1); // 27
        add(0,0,0,0, 32'h0,         1, 32'h00800413,  1, 0, 32'h0,        32'h00800413, 32'h0,        32'h4,        1); // 28
        // reset in WAIT, stale response right after release ignored
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h4,        NOP,          32'h0,        32'h0,        1); // 29
        add(1,0,0,0, 32'h0,         0, 32'h0,         1, 0, 32'h4,        NOP,          32'h0,        32'h0,        1); // 30
        add(0,0,0,0, 32'h0,         1, 32'hDEADBEEF,  1, 1, 32'h0,        NOP,          32'h0,        32'h0,        1); // 31
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 0, 32'h0,        NOP,          32'h0,        32'h0,        1); // 32
        add(0,0,0,0, 32'h0,         1, 32'h00900493,  1, 0, 32'h0,        32'h00900493, 32'h0,        32'h4,        1); // 33
        // hazard in FETCH/WAIT without response keeps IF/ID
        add(0,1,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h4,        32'h00900493, 32'h0,        32'h4,        1); // 34
        add(0,1,0,0, 32'h0,         0, 32'h0,         1, 0, 32'h4,        32'h00900493, 32'h0,        32'h4,        1); // 35
        add(0,0,0,0, 32'h0,         1, 32'h00A00513,  1, 0, 32'h4,        32'h00A00513, 32'h4,        32'h8,        1); // 36
        // second flush while draining updates pc and stays in DRAIN
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h8,        NOP,          32'h0,        32'h0,        1); // 37
        add(0,0,0,1, 32'h300,       0, 32'h0,         1, 0, 32'h8,        NOP,          32'h0,        32'h0,        1); // 38
        add(0,0,0,1, 32'h400,       0, 32'h0,         1, 0, 32'h300,      NOP,          32'h0,        32'h0,        1); // 39
        add(0,0,0,0, 32'h0,         1, 32'h12345678,  1, 0, 32'h400,      NOP,          32'h0,        32'h0,        1); // 40
        add(0,0,0,0, 32'h0,         0, 32'h0,         1, 1, 32'h400,      NOP,          32'h0,        32'h0,        1); // 41

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst         = tbl[i].rst;
            hazard      = tbl[i].haz;
            stall_mem   = tbl[i].stl;
            flush       = tbl[i].fl;
            redirect_pc = tbl[i].rpc;
            imem_rdy    = tbl[i].rdy;
            imem_rdata  = tbl[i].rdat;
            exp_q.push_back(tbl[i]);
            #1;
            if (tbl[i].pre) begin
                chk("imem_req", i, {31'd0, imem_req}, {31'd0, tbl[i].e_req});
                chk("imem_addr", i, imem_addr, tbl[i].e_addr);
            end
`ifdef FETCH_PERF_EN
            if (i == 31) begin
                chk("fetch_count_after_rst", i, fetch_count, 32'd0);
                chk("bubble_count_after_rst", i, bubble_count, 32'd0);
            end
`endif
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("instruction", i, instruction, e.e_ins);
            chk("curr_pc", i, curr_pc, e.e_cur);
            chk("next_pc", i, next_pc, e.e_nxt);
            chk("if_busy", i, {31'd0, if_busy}, {31'd0, e.e_busy});
`ifdef FETCH_PERF_EN
            if (i == 3) begin
                chk("fetch_count", i, fetch_count, 32'd1);
                chk("bubble_count", i, bubble_count, 32'd1);
            end
`endif
            n_vec++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSN, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: hazard  in  1  load-use hold of IF/ID; stall_mem  in  1  memory stall, freezes whole stage.
REQ-005 SHALL have ports: flush  in  1  taken branch/jump/rti; redirect_pc  in  32  target, valid when flush=1.
REQ-006 SHALL have ports: imem_req  out  1  fetch request; imem_addr  out  32  word-aligned fetch address.
REQ-007 SHALL have ports: imem_rdy  in  1  response valid, one per request; imem_rdata  in  32  returned instruction.
REQ-008 SHALL have ports: instruction, curr_pc, next_pc  out  32 each  IF/ID register to decode; if_busy  out  1  high when fetch has no instruction ready.

Function
REQ-009 SHALL implement FSM states FETCH, WAIT, HOLD, DRAIN; reset state FETCH.
REQ-010 FETCH: SHALL drive imem_req=1, imem_addr=pc for one cycle, then go to WAIT; imem_req=0 in all other states.
REQ-011 WAIT with imem_rdy=1 and accept (~hazard & ~stall_mem): SHALL load IF/ID {imem_rdata, pc, pc+4}, set pc<=pc+4, go to FETCH.
REQ-012 WAIT with imem_rdy=1 and no accept: SHALL capture imem_rdata into the hold buffer and go to HOLD.
REQ-013 HOLD: SHALL load IF/ID from the hold buffer on the first accept cycle, set pc<=pc+4, and go to FETCH.
REQ-014 WAIT with imem_rdy=0 and accept: SHALL load IF/ID with {NOP_INSN, 0, 0}, inserting a bubble.
REQ-015 No accept: SHALL keep the IF/ID register unchanged.
REQ-016 flush SHALL take priority over hazard and stall_mem: pc<=redirect_pc, IF/ID<={NOP_INSN,0,0}, hold buffer discarded.
REQ-017 flush in WAIT with imem_rdy=0: SHALL go to DRAIN; in any other case SHALL go to FETCH.
REQ-018 DRAIN: SHALL discard the response on imem_rdy=1 and then go to FETCH; a second flush in DRAIN SHALL update pc and stay in DRAIN.
REQ-019 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); imem_addr[1:0] SHALL always be 2'b00 (redirect_pc[1:0] ignored).
REQ-020 if_busy SHALL be 1 in FETCH, WAIT and DRAIN, and 0 in HOLD.
REQ-021 No more than one imem request SHALL be outstanding at any time.

Reset
REQ-022 rst=1 SHALL give: pc=RESET_PC, state FETCH, instruction=NOP_INSN, curr_pc=0, next_pc=0, imem_req=0, hold buffer cleared.
REQ-023 rst mid-WAIT SHALL abandon the request, and SHALL ignore any imem_rdy in the first cycle after reset release.
REQ-024 rst SHALL override flush, hazard and stall_mem.

Configuration
REQ-025 With FETCH_PERF_EN defined, SHALL add outputs fetch_count[31:0] (IF/ID loads of real instructions) and bubble_count[31:0] (NOP loads, including flush), both wrapping and cleared by rst.
REQ-026 Without FETCH_PERF_EN, the counters and their ports SHALL be absent, with no other behavioural change.

Structure
REQ-027 proc_pkg SHALL hold the NOP constant, the fetch_state_t enum (FETCH, WAIT, HOLD, DRAIN) and the PC width constant.
REQ-028 The block SHALL instantiate one sub-module, pc_gen: pc register plus next-pc mux (reset / redirect / +4 / hold).

Verification
REQ-029 Reset then imem_rdy one cycle after each req, no stalls: addresses 0,4,8; instruction/curr_pc/next_pc follow one instruction per 2 cycles, with NOP bubbles between.
REQ-030 imem_rdy with rdata=32'h00A00093 while hazard=1 for 3 cycles: state HOLD, IF/ID unchanged; on hazard release IF/ID=32'h00A00093, curr_pc=0.
REQ-031 flush with redirect_pc=32'h100 in WAIT, rdy 2 cycles later with rdata=32'hDEADBEEF: response dropped, next imem_addr=32'h100, IF/ID=NOP.
REQ-032 stall_mem=1 with imem_rdy=1: response held in HOLD, no pc advance; flush in the same cycle: redirect wins, hold buffer discarded.
REQ-033 redirect_pc=32'hFFFF_FFFC, then accept: next_pc=0, next imem_addr=0.
REQ-034 rst asserted in WAIT, stale imem_rdy in the first cycle after release: ignored, imem_addr=RESET_PC; with FETCH_PERF_EN, counters read 0.
